// File: rtl/fft_bitrev_reorder_pkg.sv
`default_nettype none
// ============================================================================
// Package    : fft_pkg
// Description: Shared definitions for the streaming radix-2 FFT datapath:
//              default frame geometry, complex sample type, and the
//              bit-reversal helper used by both the core and the reorder
//              buffer.
// Revision   : 1.0 - initial release
// ============================================================================
package fft_pkg;

  localparam int c_default_n     = 1024;
  localparam int c_default_width = 16;

  // Complex sample at the default component width.
  typedef struct packed {
    logic signed [c_default_width-1:0] re;
    logic signed [c_default_width-1:0] im;
  } cplx_t;

  // Reverses the low log2n bits of value; bits above log2n come back as 0.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int log2n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < log2n) begin
        r[5'(log2n - 1 - i)] = value[5'(i)];
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_bitrev_reorder_if.sv
`default_nettype none
// ============================================================================
// Interface  : fft_bitrev_reorder_if
// Description: Input and output valid/ready streams of the bit-reversal
//              reorder buffer.
//   in_re/in_im/in_valid -> buffer, in_ready <- buffer (bit-reversed order)
//   out_re/out_im/out_valid/out_index/out_last <- buffer, out_ready -> buffer
//   slave  : the reorder buffer itself
//   master : the environment (FFT core upstream + consumer downstream)
// Revision   : 1.0 - initial release
// ============================================================================
interface fft_bitrev_reorder_if
  import fft_pkg::*;
#(
  parameter int WIDTH = c_default_width,
  parameter int N     = c_default_n,
  parameter int LOG2N = $clog2(N)
);
  logic [WIDTH-1:0] in_re;
  logic [WIDTH-1:0] in_im;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_re;
  logic [WIDTH-1:0] out_im;
  logic             out_valid;
  logic             out_ready;
  logic [LOG2N-1:0] out_index;
  logic             out_last;

  modport slave (
    input  in_re, in_im, in_valid, out_ready,
    output in_ready, out_re, out_im, out_valid, out_index, out_last
  );

  modport master (
    output in_re, in_im, in_valid, out_ready,
    input  in_ready, out_re, out_im, out_valid, out_index, out_last
  );
endinterface
`default_nettype wire

// File: rtl/fft_sdp_ram.sv
`default_nettype none
// ============================================================================
// Module     : fft_sdp_ram
// Description: Simple dual-port RAM, one write port and one registered read
//              port (1-cycle latency). The array has no reset.
//   clk     : clock
//   i_we    : write enable,  i_waddr / i_wdata : write address / data
//   i_re    : read enable,   i_raddr           : read address
//   o_rdata : read data, updated only on the edge after an enabled read
// Revision   : 1.0 - initial release
// ============================================================================
module fft_sdp_ram #(
  parameter int DEPTH = 2048,
  parameter int DW    = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  wire logic          clk,
  input  wire logic          i_we,
  input  wire logic [AW-1:0] i_waddr,
  input  wire logic [DW-1:0] i_wdata,
  input  wire logic          i_re,
  input  wire logic [AW-1:0] i_raddr,
  output logic      [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;
endmodule
`default_nettype wire

// File: rtl/fft_bitrev_reorder.sv
`default_nettype none
// ============================================================================
// Module     : fft_bitrev_reorder
// Description: Ping-pong reorder buffer. Frames of N samples arrive in
//              bit-reversed order and leave in natural order, 1 sample/clock.
//   clk  : clock (rising edge)
//   rst  : synchronous active-high reset, discards all buffered frames
//   bus  : slave side of fft_bitrev_reorder_if (input and output streams)
// Revision   : 1.0 - initial release
// ============================================================================
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int WIDTH = c_default_width,
  parameter int N     = c_default_n,
  parameter int LOG2N = $clog2(N)
) (
  input  wire logic           clk,
  input  wire logic           rst,
  fft_bitrev_reorder_if.slave bus
);
  localparam int               c_dw   = 2 * WIDTH;
  localparam logic [LOG2N-1:0] c_last = LOG2N'(N - 1);

  // Write side
  logic             r_wr_bank;
  logic [LOG2N-1:0] r_wr_cnt;
  logic [1:0]       r_full;
  // Read side
  logic             r_rd_bank;
  logic [LOG2N-1:0] r_rd_addr;
  logic             r_inflight;
  logic [LOG2N-1:0] r_inflight_idx;
  // Skid FIFO, entry 0 is the head
  logic [WIDTH-1:0] r_sk_re  [2];
  logic [WIDTH-1:0] r_sk_im  [2];
  logic [LOG2N-1:0] r_sk_idx [2];
  logic [1:0]       r_sk_cnt;

  logic             w_in_ready;
  logic             w_in_fire;
  logic [LOG2N-1:0] w_wr_off;
  logic [c_dw-1:0]  w_rd_data;
  logic [WIDTH-1:0] w_ram_re;
  logic [WIDTH-1:0] w_ram_im;
  logic             w_head_from_ram;
  logic             w_out_valid;
  logic [LOG2N-1:0] w_out_index;
  logic             w_pop;
  logic             w_pop_skid;
  logic             w_push;
  logic [2:0]       w_occ;
  logic             w_issue;
  logic [1:0]       w_set;
  logic [1:0]       w_clr;

  assign w_in_ready = !r_full[r_wr_bank] && !rst;
  assign w_in_fire  = bus.in_valid && w_in_ready;
  assign w_wr_off   = LOG2N'(bitrev(32'(r_wr_cnt), LOG2N));

  // The RAM output register doubles as the FIFO tail: a sample read last
  // cycle is already presentable, and it only moves into a skid entry if it
  // is not consumed straight away.
  assign w_ram_re        = w_rd_data[c_dw-1:WIDTH];
  assign w_ram_im        = w_rd_data[WIDTH-1:0];
  assign w_head_from_ram = r_inflight && (r_sk_cnt == 2'd0);
  assign w_out_valid     = r_inflight || (r_sk_cnt != 2'd0);
  assign w_pop           = w_out_valid && bus.out_ready;
  assign w_pop_skid      = w_pop && (r_sk_cnt != 2'd0);
  assign w_push          = r_inflight && !(w_head_from_ram && w_pop);

  // Samples held after this cycle; keeping it below 2 before issuing means
  // the skid can never overflow even with the consumer stalled.
  assign w_occ   = {1'b0, r_sk_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = r_full[r_rd_bank] && (w_occ < 3'd2);

  // Completing a bank and releasing the other can coincide; they touch
  // different bits since the writer never owns the bank being read.
  assign w_set = (w_in_fire && (r_wr_cnt == c_last)) ? (2'b01 << r_wr_bank) : 2'b00;
  assign w_clr = (w_issue && (r_rd_addr == c_last)) ? (2'b01 << r_rd_bank) : 2'b00;

  fft_sdp_ram #(
    .DEPTH (2 * N),
    .DW    (c_dw)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_in_fire),
    .i_waddr ({r_wr_bank, w_wr_off}),
    .i_wdata ({bus.in_re, bus.in_im}),
    .i_re    (w_issue),
    .i_raddr ({r_rd_bank, r_rd_addr}),
    .o_rdata (w_rd_data)
  );

  // Bank bookkeeping and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_bank      <= 1'b0;
      r_wr_cnt       <= '0;
      r_full         <= 2'b00;
      r_rd_bank      <= 1'b0;
      r_rd_addr      <= '0;
      r_inflight     <= 1'b0;
      r_inflight_idx <= '0;
    end else begin
      if (w_in_fire) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
        if (r_wr_cnt == c_last) begin
          r_wr_bank <= ~r_wr_bank;
        end
      end
      r_full     <= (r_full | w_set) & ~w_clr;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_idx <= r_rd_addr;
        r_rd_addr      <= r_rd_addr + 1'b1;
        if (r_rd_addr == c_last) begin
          r_rd_bank <= ~r_rd_bank;
        end
      end
    end
  end

  // Skid FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sk_cnt <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_sk_re[i]  <= '0;
        r_sk_im[i]  <= '0;
        r_sk_idx[i] <= '0;
      end
    end else begin
      case ({w_push, w_pop_skid})
        2'b10: begin
          r_sk_re[r_sk_cnt[0]]  <= w_ram_re;
          r_sk_im[r_sk_cnt[0]]  <= w_ram_im;
          r_sk_idx[r_sk_cnt[0]] <= r_inflight_idx;
          r_sk_cnt              <= r_sk_cnt + 2'd1;
        end
        2'b01: begin
          r_sk_re[0]  <= r_sk_re[1];
          r_sk_im[0]  <= r_sk_im[1];
          r_sk_idx[0] <= r_sk_idx[1];
          r_sk_cnt    <= r_sk_cnt - 2'd1;
        end
        2'b11: begin
          if (r_sk_cnt == 2'd1) begin
            r_sk_re[0]  <= w_ram_re;
            r_sk_im[0]  <= w_ram_im;
            r_sk_idx[0] <= r_inflight_idx;
          end else begin
            r_sk_re[0]  <= r_sk_re[1];
            r_sk_im[0]  <= r_sk_im[1];
            r_sk_idx[0] <= r_sk_idx[1];
            r_sk_re[1]  <= w_ram_re;
            r_sk_im[1]  <= w_ram_im;
            r_sk_idx[1] <= r_inflight_idx;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_out_index   = w_head_from_ram ? r_inflight_idx : r_sk_idx[0];
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_re    = w_head_from_ram ? w_ram_re : r_sk_re[0];
  assign bus.out_im    = w_head_from_ram ? w_ram_im : r_sk_im[0];
  assign bus.out_index = w_out_index;
  assign bus.out_last  = w_out_valid && (w_out_index == c_last);
endmodule
`default_nettype wire

// File: tb/tb_fft_bitrev_reorder.sv
`default_nettype none
// ============================================================================
// Module     : tb_fft_bitrev_reorder
// Description: Self-checking bench for fft_bitrev_reorder. An N=8 instance
//              covers the small hand-written frame; an N=1024 instance covers
//              streaming, backpressure, random stalls and mid-frame reset
//              against a frame-level reference model.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_fft_bitrev_reorder;
  localparam int W  = 16;
  localparam int NB = 1024;
  localparam int LB = 10;
  localparam int NS = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_bitrev_reorder_if #(.WIDTH(W), .N(NB)) bus ();
  fft_bitrev_reorder_if #(.WIDTH(W), .N(NS)) bus8 ();

  fft_bitrev_reorder #(.WIDTH(W), .N(NB)) dut  (.clk(clk), .rst(rst), .bus(bus));
  fft_bitrev_reorder #(.WIDTH(W), .N(NS)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  int errors = 0;
  int checks = 0;

  // Reference model: each input frame is collected into natural order, and a
  // completed frame is appended to the queue of expected outputs.
  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    int           idx;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] fb_re [NB];
  logic [W-1:0] fb_im [NB];
  int           in_pos = 0;

  function automatic int tbrev(int v, int bits);
    int r;
    int x;
    r = 0;
    x = v;
    for (int i = 0; i < bits; i++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  function automatic void model_accept(logic [W-1:0] re, logic [W-1:0] im);
    int   j;
    exp_t e;
    j        = tbrev(in_pos, LB);
    fb_re[j] = re;
    fb_im[j] = im;
    in_pos++;
    if (in_pos == NB) begin
      for (int i = 0; i < NB; i++) begin
        e.re  = fb_re[i];
        e.im  = fb_im[i];
        e.idx = i;
        exp_q.push_back(e);
      end
      in_pos = 0;
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    in_pos = 0;
  endfunction

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_re     = 16'h1234;
    bus.in_im     = 16'h5678;
    bus.out_ready = 1'b1;
    bus8.in_valid = 1'b1;
    bus8.in_re    = 16'h0abc;
    bus8.in_im    = 16'h0def;
    bus8.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0 || bus8.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_in_ready: cycle %0d got %b/%b, expected 0/0", c, bus.in_ready, bus8.in_ready);
      end
      checks++;
      if (bus.out_valid !== 1'b0 || bus8.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_out_valid: cycle %0d got %b/%b, expected 0/0", c, bus.out_valid, bus8.out_valid);
      end
    end
    checks++;
    if ({bus.out_re, bus.out_im, bus.out_index, bus.out_last} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got re=%h im=%h idx=%0d last=%b, expected all 0",
               bus.out_re, bus.out_im, bus.out_index, bus.out_last);
    end
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus8.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus8.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: in_ready got %b/%b, expected 1/1", bus.in_ready, bus8.in_ready);
    end
  endtask

  task automatic test_single_n8();
    int re_seq[8];
    int nacc;
    int nout;
    int acc_cyc;
    int rise_cyc;
    re_seq   = '{0, 4, 2, 6, 1, 5, 3, 7};
    nacc     = 0;
    nout     = 0;
    acc_cyc  = -1;
    rise_cyc = -1;
    @(posedge clk);
    #1;
    bus8.out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (nacc < 8) begin
        bus8.in_valid = 1'b1;
        bus8.in_re    = W'(re_seq[nacc]);
        bus8.in_im    = W'(-re_seq[nacc]);
      end else begin
        bus8.in_valid = 1'b0;
      end
      @(negedge clk);
      if (bus8.out_valid && rise_cyc < 0) rise_cyc = c;
      if (bus8.out_valid && bus8.out_ready) begin
        checks++;
        if (bus8.out_re !== W'(nout) || bus8.out_im !== W'(-nout) ||
            bus8.out_index !== 3'(nout) || bus8.out_last !== (nout == 7)) begin
          errors++;
          $display("FAIL n8_out: got re=%0d im=%h idx=%0d last=%b, expected re=%0d im=%h idx=%0d last=%b",
                   bus8.out_re, bus8.out_im, bus8.out_index, bus8.out_last,
                   nout, W'(-nout), nout, (nout == 7));
        end
        nout++;
      end
      if (bus8.in_valid && bus8.in_ready) begin
        nacc++;
        if (nacc == 8) acc_cyc = c;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (nout != 8) begin
      errors++;
      $display("FAIL n8_count: got %0d outputs, expected 8", nout);
    end
    checks++;
    if (rise_cyc != acc_cyc + 2) begin
      errors++;
      $display("FAIL n8_latency: out_valid rose at cycle %0d, expected %0d", rise_cyc, acc_cyc + 2);
    end
  endtask

  task automatic test_back_to_back();
    int   sent;
    int   got;
    int   first;
    int   bubbles;
    int   stalls;
    exp_t e;
    sent    = 0;
    got     = 0;
    first   = -1;
    bubbles = 0;
    stalls  = 0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6000 && got < 3 * NB; c++) begin
      if (sent < 3 * NB) begin
        bus.in_valid = 1'b1;
        bus.in_re    = W'(tbrev(sent % NB, LB) + NB * (sent / NB));
        bus.in_im    = W'($urandom);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (bus.in_valid && !bus.in_ready) stalls++;
      if (bus.in_valid && bus.in_ready) begin
        model_accept(bus.in_re, bus.in_im);
        sent++;
      end
      if (first >= 0 && !bus.out_valid) bubbles++;
      if (bus.out_valid && bus.out_ready) begin
        if (first < 0) first = c;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_out: got unexpected sample idx=%0d, expected none", bus.out_index);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_re !== e.re || bus.out_im !== e.im || bus.out_index !== LB'(e.idx) ||
              bus.out_last !== (e.idx == NB - 1)) begin
            errors++;
            $display("FAIL b2b_out: got re=%h im=%h idx=%0d last=%b, expected re=%h im=%h idx=%0d last=%b",
                     bus.out_re, bus.out_im, bus.out_index, bus.out_last, e.re, e.im, e.idx, (e.idx == NB - 1));
          end
        end
        got++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (got != 3 * NB) begin
      errors++;
      $display("FAIL b2b_count: got %0d outputs, expected %0d", got, 3 * NB);
    end
    checks++;
    if (bubbles != 0) begin
      errors++;
      $display("FAIL b2b_bubbles: got %0d idle output cycles, expected 0", bubbles);
    end
    checks++;
    if (stalls != 0) begin
      errors++;
      $display("FAIL b2b_in_ready: got %0d cycles with in_ready low, expected 0", stalls);
    end
  endtask

  task automatic test_backpressure();
    int   acc;
    int   got;
    int   rise;
    exp_t e;
    acc  = 0;
    got  = 0;
    rise = -1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 2200; c++) begin
      bus.in_valid = 1'b1;
      bus.in_re    = W'($urandom);
      bus.in_im    = W'($urandom);
      @(negedge clk);
      if (bus.in_ready) begin
        model_accept(bus.in_re, bus.in_im);
        acc++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (acc != 2 * NB) begin
      errors++;
      $display("FAIL bp_absorb: got %0d accepted, expected %0d", acc, 2 * NB);
    end
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_index !== '0) begin
      errors++;
      $display("FAIL bp_blocked: got in_ready=%b out_valid=%b idx=%0d, expected 0 1 0",
               bus.in_ready, bus.out_valid, bus.out_index);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 2400 && got < 2 * NB; c++) begin
      @(negedge clk);
      if (rise < 0 && bus.in_ready) rise = c;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bp_out: got unexpected sample idx=%0d, expected none", bus.out_index);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_re !== e.re || bus.out_im !== e.im || bus.out_index !== LB'(e.idx) ||
              bus.out_last !== (e.idx == NB - 1)) begin
            errors++;
            $display("FAIL bp_out: got re=%h im=%h idx=%0d last=%b, expected re=%h im=%h idx=%0d last=%b",
                     bus.out_re, bus.out_im, bus.out_index, bus.out_last, e.re, e.im, e.idx, (e.idx == NB - 1));
          end
        end
        got++;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (got != 2 * NB) begin
      errors++;
      $display("FAIL bp_count: got %0d outputs, expected %0d", got, 2 * NB);
    end
    // Reads run two samples ahead of the output, so the last read of bank 0
    // is issued while sample N-3 is at the output.
    checks++;
    if (rise != NB - 2) begin
      errors++;
      $display("FAIL bp_release: in_ready returned at drain cycle %0d, expected %0d", rise, NB - 2);
    end
  endtask

  task automatic test_random_stall();
    int           sent;
    int           got;
    exp_t         e;
    logic         prev_hold;
    logic [W-1:0] p_re;
    logic [W-1:0] p_im;
    logic [LB-1:0] p_idx;
    logic         p_last;
    logic [W-1:0] d_re;
    logic [W-1:0] d_im;
    sent      = 0;
    got       = 0;
    prev_hold = 1'b0;
    p_re      = '0;
    p_im      = '0;
    p_idx     = '0;
    p_last    = 1'b0;
    d_re      = W'($urandom);
    d_im      = W'($urandom);
    @(posedge clk);
    #1;
    for (int c = 0; c < 40000 && got < 10 * NB; c++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      if (sent < 10 * NB) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_re    = d_re;
        bus.in_im    = d_im;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (prev_hold) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_re !== p_re || bus.out_im !== p_im ||
            bus.out_index !== p_idx || bus.out_last !== p_last) begin
          errors++;
          $display("FAIL stall_hold: got v=%b re=%h im=%h idx=%0d, expected v=1 re=%h im=%h idx=%0d",
                   bus.out_valid, bus.out_re, bus.out_im, bus.out_index, p_re, p_im, p_idx);
        end
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      p_re      = bus.out_re;
      p_im      = bus.out_im;
      p_idx     = bus.out_index;
      p_last    = bus.out_last;
      if (bus.in_valid && bus.in_ready) begin
        model_accept(bus.in_re, bus.in_im);
        sent++;
        d_re = W'($urandom);
        d_im = W'($urandom);
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rnd_out: got unexpected sample idx=%0d, expected none", bus.out_index);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_re !== e.re || bus.out_im !== e.im || bus.out_index !== LB'(e.idx) ||
              bus.out_last !== (e.idx == NB - 1)) begin
            errors++;
            $display("FAIL rnd_out: got re=%h im=%h idx=%0d last=%b, expected re=%h im=%h idx=%0d last=%b",
                     bus.out_re, bus.out_im, bus.out_index, bus.out_last, e.re, e.im, e.idx, (e.idx == NB - 1));
          end
        end
        got++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (got != 10 * NB) begin
      errors++;
      $display("FAIL rnd_count: got %0d outputs, expected %0d", got, 10 * NB);
    end
  endtask

  task automatic test_reset_mid();
    int   sent;
    int   got;
    exp_t e;
    sent = 0;
    got  = 0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4000 && sent < NB + 500; c++) begin
      bus.in_valid = 1'b1;
      bus.in_re    = W'($urandom);
      bus.in_im    = W'($urandom);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        model_accept(bus.in_re, bus.in_im);
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL mid_pre: got unexpected sample idx=%0d, expected none", bus.out_index);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_re !== e.re || bus.out_im !== e.im || bus.out_index !== LB'(e.idx)) begin
            errors++;
            $display("FAIL mid_pre: got re=%h im=%h idx=%0d, expected re=%h im=%h idx=%0d",
                     bus.out_re, bus.out_im, bus.out_index, e.re, e.im, e.idx);
          end
        end
      end
      @(posedge clk);
      #1;
    end
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got out_valid=%b out_last=%b in_ready=%b, expected 0 0 1",
               bus.out_valid, bus.out_last, bus.in_ready);
    end
    sent = 0;
    @(posedge clk);
    #1;
    for (int c = 0; c < 2400 && got < NB; c++) begin
      if (sent < NB) begin
        bus.in_valid = 1'b1;
        bus.in_re    = W'($urandom);
        bus.in_im    = W'($urandom);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        model_accept(bus.in_re, bus.in_im);
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL mid_post: got unexpected sample idx=%0d, expected none", bus.out_index);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_re !== e.re || bus.out_im !== e.im || bus.out_index !== LB'(e.idx) ||
              bus.out_last !== (e.idx == NB - 1)) begin
            errors++;
            $display("FAIL mid_post: got re=%h im=%h idx=%0d last=%b, expected re=%h im=%h idx=%0d last=%b",
                     bus.out_re, bus.out_im, bus.out_index, bus.out_last, e.re, e.im, e.idx, (e.idx == NB - 1));
          end
        end
        got++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (got != NB) begin
      errors++;
      $display("FAIL mid_count: got %0d outputs after reset, expected %0d", got, NB);
    end
  endtask

  initial begin
    test_reset();
    test_single_n8();
    test_back_to_back();
    test_backpressure();
    test_random_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fft_bitrev_reorder.md
# fft_bitrev_reorder

Output-side reorder buffer for the streaming radix-2 FFT. Accepts one frame of N complex samples per frame in bit-reversed index order from the FFT core's output stream and re-emits each frame in natural order (index 0..N-1) on a valid/ready stream. It uses two ping-pong banks, so one frame is written while the previous one drains, and sustains 1 sample/clock.

## Interface
Parameters:
- WIDTH, 16, bits per real/imaginary component (signed two's complement)
- N, 1024, frame length; power of two, minimum 4
- LOG2N, $clog2(N), derived; do not override

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_re  in  WIDTH  sample real part, bit-reversed order
- in_im  in  WIDTH  sample imaginary part
- in_valid  in  1  input sample present
- in_ready  out  1  block can accept; a sample transfers when in_valid && in_ready
- out_re  out  WIDTH  sample real part, natural order
- out_im  out  WIDTH  sample imaginary part
- out_valid  out  1  output sample present
- out_ready  in  1  downstream accepts; a sample transfers when out_valid && out_ready
- out_index  out  LOG2N  natural-order index of the current output sample
- out_last  out  1  high with index N-1 (end of frame)

## Operation
- Storage: one simple dual-port RAM of 2N x 2*WIDTH. Address = {bank, offset}. One write port and one read port, both used in the same cycle. Read latency is 1 cycle.
- Write side:
  - wr_bank (1b) and wr_cnt (LOG2N b).
  - On an input handshake, write {in_re,in_im} to {wr_bank, bitrev(wr_cnt)}.
  - Then increment wr_cnt. When wr_cnt wraps from N-1 to 0, set full[wr_bank] and toggle wr_bank.
- in_ready = !full[wr_bank] && !rst.
- Read side:
  - rd_bank (1b) and rd_addr (LOG2N b).
  - Issue a read of {rd_bank, rd_addr} when full[rd_bank] && (skid occupancy + reads in flight − pop this cycle) < 2.
  - On issue, rd_addr increments. On the issue of rd_addr = N-1: clear full[rd_bank], toggle rd_bank, and wrap rd_addr to 0.
- Output stage:
  - A 2-entry skid FIFO holds {re, im, index}. RAM data enters the FIFO the cycle after issue.
  - out_* present the FIFO head. out_valid = FIFO non-empty.
  - out_last = (out_index == N-1) && out_valid.
- Outputs hold stable while out_valid && !out_ready.
- Data passes through unmodified: no scaling, rounding, or sign handling.
- Frames never interleave; output frame order equals input frame order.

## Timing
- Reset (rst sampled high) produces the following on the next edge:
  - wr_cnt = 0, rd_addr = 0, wr_bank = 0, rd_bank = 0, full = 2'b00, skid empty.
  - out_valid = 0, out_last = 0, out_index = 0, out_re/out_im = 0, in_ready = 0 while rst is high.
  - in_ready = 1 in the first cycle after rst deasserts.
- Reset mid-frame discards all partial and complete frames, including data in the skid.
- Latency: with out_ready = 1, out_valid rises 2 cycles after the cycle containing the Nth input handshake of a frame: full set at edge 1, read issued, data in skid at edge 2.
- Throughput: with out_ready held high, 1 sample/clock in and out indefinitely; in_ready never drops.
- Bank release: full clears at the edge of the last read issue. The writer may write that bank from the next cycle onward.
- Backpressure: with out_ready = 0, the block absorbs exactly 2N samples. in_ready then stays low until a bank is released.
- Simultaneous events:
  - A write completing bank A and the last read of bank B in the same cycle both take effect. The resulting states are independent.
  - Skid push and pop in the same cycle keep the occupancy unchanged.

## Structure
- The package fft_pkg holds:
  - function bitrev(value, LOG2N), shared with the FFT core.
  - typedef for the complex sample {re, im} of WIDTH.
  - the default N/WIDTH localparams.
- The sub-module fft_sdp_ram holds the RAM: parameterised depth/width, 1 write port, 1 registered read port, no reset on the array. Everything else (counters, bank flags, skid) lives in fft_bitrev_reorder.

## Test plan
- Reset: hold rst 3 cycles with in_valid = 1 -> in_ready = 0 and out_valid = 0 throughout. in_ready = 1 in the first cycle after release.
- Single frame, N = 8: feed re = 0,4,2,6,1,5,3,7 and im = −re -> out re = 0..7 with out_index = re. out_last only at index 7. out_valid rises 2 cycles after the 8th accept.
- Full N = 1024, three back-to-back frames with out_ready = 1, input k carries re = bitrev(k) + 1024·frame -> 3072 outputs in natural order with no bubbles. in_ready is never 0.
- Backpressure: out_ready = 0 and feed continuously -> exactly 2048 accepted, then in_ready = 0. Raise out_ready -> frame 0 then frame 1 emerge in order. in_ready returns the cycle after the last read of bank 0 is issued.
- Random stall: in_valid and out_ready each 50% random for 10 frames -> scoreboard shows no loss, duplication, or reordering. Outputs are stable during stalls.
- Reset mid-operation: rst after 500 inputs of frame 1 while frame 0 drains -> out_valid = 0 next cycle. The next fed frame emerges from index 0 with the correct data.
